// File: rtl/i2s_line_in_rx_if.sv
// rtl/i2s_line_in_rx_if.sv - I2S line-in serial pins and parallel sample outputs
// The master drives the codec pins; the slave is the receiver that returns samples.
interface i2s_line_in_rx_if #(
  parameter int SAMPLE_BITS = 24
);
  logic                   bclk_in;
  logic                   lrclk_in;
  logic                   sdata_in;
  logic [SAMPLE_BITS-1:0] line_in_l;
  logic [SAMPLE_BITS-1:0] line_in_r;
  logic                   new_sample;
  logic                   frame_err;

  modport master (
    output bclk_in,
    output lrclk_in,
    output sdata_in,
    input  line_in_l,
    input  line_in_r,
    input  new_sample,
    input  frame_err
  );

  modport slave (
    input  bclk_in,
    input  lrclk_in,
    input  sdata_in,
    output line_in_l,
    output line_in_r,
    output new_sample,
    output frame_err
  );
endinterface

// File: rtl/i2s_line_in_rx.sv
// rtl/i2s_line_in_rx.sv - oversampled I2S ADC receiver producing stereo sample pairs
// BCLK/LRCLK are treated as data and edge-detected in the clk domain.
module i2s_line_in_rx #(
  parameter int SAMPLE_BITS = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  i2s_line_in_rx_if.slave      bus
);

  localparam logic [5:0] BITS = 6'(SAMPLE_BITS);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   bclk_hist_q;
  logic                   lrclk_hist_q;

  state_t                 state_q;
  logic                   chan_q;
  logic [5:0]             bit_cnt_q;
  logic [SAMPLE_BITS-1:0] shift_q;
  logic [SAMPLE_BITS-1:0] hold_l_q;
  logic                   left_valid_q;
  logic                   load_r_q;
  logic [SAMPLE_BITS-1:0] line_l_q;
  logic [SAMPLE_BITS-1:0] line_r_q;
  logic                   new_sample_q;
  logic                   frame_err_q;

  logic                   bclk_s;
  logic                   lrclk_s;
  logic                   sdata_s;
  logic                   bclk_rise;
  logic                   lr_edge;
  logic [5:0]             bit_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_hist_q  <= 1'b0;
      lrclk_hist_q <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bus.bclk_in};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], bus.lrclk_in};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], bus.sdata_in};
      bclk_hist_q  <= bclk_s;
      lrclk_hist_q <= lrclk_s;
    end
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrclk_s   = lrclk_sync_q[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_hist_q;
  assign lr_edge   = lrclk_s ^ lrclk_hist_q;
  assign bit_cnt_d = bit_cnt_q + 6'd1;
  assign shift_d   = {shift_q[SAMPLE_BITS-2:0], sdata_s};

  // A rise coinciding with a slot edge is the I2S delay bit, so those paths go straight to SHIFT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      chan_q       <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_l_q     <= '0;
      left_valid_q <= 1'b0;
      load_r_q     <= 1'b0;
      line_l_q     <= '0;
      line_r_q     <= '0;
      new_sample_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      new_sample_q <= 1'b0;
      frame_err_q  <= 1'b0;
      load_r_q     <= 1'b0;

      if (load_r_q && enable) begin
        line_l_q     <= hold_l_q;
        line_r_q     <= shift_q;
        new_sample_q <= 1'b1;
      end

      if (!enable) begin
        state_q      <= IDLE;
        left_valid_q <= 1'b0;
        bit_cnt_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (lr_edge && !lrclk_s) begin
              chan_q    <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= bclk_rise ? SHIFT : DELAY;
            end
          end
          DELAY: begin
            bit_cnt_q <= '0;
            if (lr_edge) begin
              chan_q  <= lrclk_s;
              state_q <= bclk_rise ? SHIFT : DELAY;
            end else if (bclk_rise) begin
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (lr_edge) begin
              frame_err_q  <= 1'b1;
              left_valid_q <= 1'b0;
              chan_q       <= lrclk_s;
              bit_cnt_q    <= '0;
              state_q      <= bclk_rise ? SHIFT : DELAY;
            end else if (bclk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_d == BITS) begin
                state_q <= PAD;
                if (!chan_q) begin
                  hold_l_q     <= shift_d;
                  left_valid_q <= 1'b1;
                end else if (left_valid_q) begin
                  load_r_q     <= 1'b1;
                  left_valid_q <= 1'b0;
                end
              end
            end
          end
          PAD: begin
            // bit_cnt stays at SAMPLE_BITS through the remaining slot bits.
            if (lr_edge) begin
              chan_q    <= lrclk_s;
              bit_cnt_q <= '0;
              state_q   <= bclk_rise ? SHIFT : DELAY;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.line_in_l  = line_l_q;
  assign bus.line_in_r  = line_r_q;
  assign bus.new_sample = new_sample_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// tb/tb_i2s_line_in_rx.sv - directed I2S frames checked against a slot-level sample model
// BCLK = clk/32; every slot is described by channel, word, length and pad bit value.
module tb_i2s_line_in_rx;

  localparam int SB = 24;
  localparam int SS = 2;
  localparam int HALF = 16;

  typedef struct {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
    longint        cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;

  i2s_line_in_rx_if #(.SAMPLE_BITS(SB)) bus();

  i2s_line_in_rx #(.SAMPLE_BITS(SB), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;
  bit started = 1'b0;

  exp_t exp_q[$];
  bit aligned = 1'b0;
  bit have_left = 1'b0;
  logic [SB-1:0] left_w = '0;
  logic [SB-1:0] cur_l = '0;
  logic [SB-1:0] cur_r = '0;
  int exp_err = 0;
  int err_seen = 0;
  int seen = 0;
  logic prev_ns = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (bus.new_sample === 1'b1) begin
        exp_t e;
        chk("new_sample_single", {31'd0, prev_ns}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_new_sample", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk_rng("latency", cyc - e.cyc, SS + 2, SS + 3);
          cur_l = e.l;
          cur_r = e.r;
          seen++;
        end
      end
      chk("line_in_l", {8'd0, bus.line_in_l}, {8'd0, cur_l});
      chk("line_in_r", {8'd0, bus.line_in_r}, {8'd0, cur_r});
      if (bus.frame_err === 1'b1) err_seen++;
      prev_ns = bus.new_sample;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One I2S slot: bit 0 is the delay bit, bits 1..24 carry the word MSB first, the rest are pad.
  task automatic send_slot(input bit chan, input logic [SB-1:0] w, input int n,
                           input bit pad, input int rst_at);
    for (int k = 0; k < n; k++) begin
      bus.bclk_in = 1'b0;
      if (k == 0) begin
        bus.lrclk_in = chan;
        if (!enable) begin
          aligned = 1'b0;
          have_left = 1'b0;
        end else if (!chan) begin
          aligned = 1'b1;
        end
      end
      bus.sdata_in = (k >= 1 && k <= SB) ? w[SB-k] : pad;
      if (k == rst_at) begin
        aligned = 1'b0;
        have_left = 1'b0;
        cur_l = '0;
        cur_r = '0;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        chk("rst_async_l", {8'd0, bus.line_in_l}, 32'd0);
        chk("rst_async_r", {8'd0, bus.line_in_r}, 32'd0);
        chk("rst_async_ns", {31'd0, bus.new_sample}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      bus.bclk_in = 1'b1;
      if (k == SB && n > SB && aligned) begin
        if (!chan) begin
          left_w = w;
          have_left = 1'b1;
        end else if (have_left) begin
          exp_q.push_back('{l: left_w, r: w, cyc: cyc});
          have_left = 1'b0;
        end
      end
      tick(HALF);
    end
    if (aligned && n <= SB) begin
      exp_err++;
      have_left = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r, input bit pad);
    send_slot(1'b0, l, 32, pad, -1);
    send_slot(1'b1, r, 32, pad, -1);
  endtask

  task automatic checkpoint(input string name);
    tick(40);
    chk({name, "_pending"}, exp_q.size(), 32'd0);
    chk({name, "_frame_err"}, err_seen, exp_err);
  endtask

  initial begin
    int seen0;
    reset_n = 1'b0;
    enable = 1'b1;
    bus.bclk_in = 1'b0;
    bus.lrclk_in = 1'b0;
    bus.sdata_in = 1'b0;
    tick(3);
    chk("reset_l", {8'd0, bus.line_in_l}, 32'd0);
    chk("reset_r", {8'd0, bus.line_in_r}, 32'd0);
    chk("reset_ns", {31'd0, bus.new_sample}, 32'd0);
    chk("reset_fe", {31'd0, bus.frame_err}, 32'd0);
    started = 1'b1;
    reset_n = 1'b1;
    tick(4);

    // Partial right slot from idle, then three good frames.
    send_slot(1'b1, 24'hFFFFFF, 12, 1'b1, -1);
    checkpoint("midslot");
    chk("midslot_no_sample", seen, 32'd0);
    for (int i = 0; i < 3; i++) send_frame(24'h123456, 24'hABCDEF, 1'b0);
    checkpoint("basic");
    chk("basic_count", seen, 32'd3);
    chk("basic_l", {8'd0, bus.line_in_l}, 32'h00123456);
    chk("basic_r", {8'd0, bus.line_in_r}, 32'h00ABCDEF);

    // Short left slot.
    seen0 = seen;
    send_slot(1'b0, 24'h111111, 16, 1'b0, -1);
    send_slot(1'b1, 24'h222222, 32, 1'b0, -1);
    checkpoint("short");
    chk("short_err_once", err_seen, 32'd1);
    chk("short_no_sample", seen - seen0, 32'd0);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    checkpoint("recover");
    chk("recover_l", {8'd0, bus.line_in_l}, 32'h000F0F0F);
    chk("recover_r", {8'd0, bus.line_in_r}, 32'h00F0F0F0);

    // Full-scale values with pad bits set.
    send_frame(24'h800000, 24'h7FFFFF, 1'b1);
    checkpoint("fullscale");
    chk("fullscale_l", {8'd0, bus.line_in_l}, 32'h00800000);
    chk("fullscale_r", {8'd0, bus.line_in_r}, 32'h007FFFFF);

    // Reset mid right slot.
    send_slot(1'b0, 24'h654321, 32, 1'b0, -1);
    send_slot(1'b1, 24'h13579B, 32, 1'b0, 10);
    checkpoint("after_rst");
    chk("after_rst_l", {8'd0, bus.line_in_l}, 32'd0);
    seen0 = seen;
    send_frame(24'hAAAAAA, 24'h555555, 1'b0);
    checkpoint("rst_pair");
    chk("rst_pair_count", seen - seen0, 32'd1);
    chk("rst_pair_l", {8'd0, bus.line_in_l}, 32'h00AAAAAA);

    // Receiver disabled for three frames.
    seen0 = seen;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(24'h000001 + 24'(i), 24'hC00000 + 24'(i), 1'b0);
    checkpoint("disabled");
    chk("disabled_no_sample", seen - seen0, 32'd0);
    chk("disabled_hold_r", {8'd0, bus.line_in_r}, 32'h00555555);
    enable = 1'b1;
    send_frame(24'h3C3C3C, 24'hC3C3C3, 1'b0);
    checkpoint("reenable");
    chk("reenable_count", seen - seen0, 32'd1);
    chk("reenable_l", {8'd0, bus.line_in_l}, 32'h003C3C3C);
    chk("reenable_r", {8'd0, bus.line_in_r}, 32'h00C3C3C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
